// File: rtl/div_clock_monitor_pkg.sv
// Shared types and defaults for the divided-clock monitor.
package div_clock_monitor_pkg;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 1000;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } mon_state_e;

    // One completed measurement at the default counter width.
    typedef struct packed {
        logic [DEF_CNT_W-1:0] period;
        logic [DEF_CNT_W-1:0] high_time;
    } meas_result_t;

endpackage

// File: rtl/div_clock_monitor_edge_detect.sv
// Rising/falling edge detector for a signal already registered in the clk domain.
module div_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    // One-cycle history of the observed signal, sampled every cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/div_clock_monitor.sv
// Measures period and high time of a divided clock in clk_in cycles and
// flags a divided clock that has stopped toggling.
//
// Result handshake: a result is transferred on every rising clk_in edge where
// meas_valid and meas_ready are both 1. meas_valid stays high until that
// transfer, and period/high_time are held stable while meas_valid=1 and
// meas_ready=0. A result completing while the held one is not being taken
// is dropped and sets the sticky overrun flag.
module div_clock_monitor
    import div_clock_monitor_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             div_clk,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             stuck,
    output logic             overrun,
    output mon_state_e       state_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             overrun_q, overrun_d;

    logic rise, fall;
    logic complete, timeout;

    div_edge_detect u_edge (
        .clk_i  (clk_in),
        .rst_ni (rst_n),
        .sig_i  (div_clk),
        .rise_o (rise),
        .fall_o (fall)
    );

    // FSM and cycle counter next state; enable low overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_cap_d = hi_cap_q;
        complete = 1'b0;
        timeout  = 1'b0;

        if (rise) begin
            cnt_d = CNT_ONE;
        end else if ((state_q == MEAS_HIGH || state_q == MEAS_LOW) && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                state_d = ARM;
            end
            ARM: begin
                // The partial period in flight at arm time is never reported.
                if (rise) begin
                    state_d = MEAS_HIGH;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    hi_cap_d = cnt_q;
                    state_d  = MEAS_LOW;
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout = 1'b1;
                    state_d = ARM;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    complete = 1'b1;
                    state_d  = MEAS_HIGH;
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout = 1'b1;
                    state_d = ARM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            hi_cap_d = '0;
            complete = 1'b0;
            timeout  = 1'b0;
        end
    end

    // Output register, handshake and status flag next state.
    always_comb begin
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = valid_q;
        stuck_d   = stuck_q;
        overrun_d = overrun_q;

        if (complete) begin
            if (!valid_q || meas_ready) begin
                period_d = cnt_q;
                high_d   = hi_cap_q;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && meas_ready) begin
            valid_d = 1'b0;
        end

        if (timeout) begin
            stuck_d = 1'b1;
        end else if (rise) begin
            stuck_d = 1'b0;
        end

        // Disabling discards status but keeps the last reported values.
        if (!enable) begin
            valid_d   = 1'b0;
            stuck_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    // State, counter and result registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_cap_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_cap_q  <= hi_cap_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
            overrun_q <= overrun_d;
        end
    end

    assign meas_valid = valid_q;
    assign period     = period_q;
    assign high_time  = high_q;
    assign stuck      = stuck_q;
    assign overrun    = overrun_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_div_clock_monitor.sv
// Randomised bench for div_clock_monitor with a timestamp-based reference model.
module tb_div_clock_monitor;
    import div_clock_monitor_pkg::*;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 20;
    localparam int W       = 2 * CNT_W;

    logic             clk_in = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             div_clk = 1'b0;
    logic             meas_ready = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             stuck;
    logic             overrun;
    mon_state_e       state_o;

    int tests = 0;
    int fails = 0;

    div_clock_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .enable     (enable),
        .div_clk    (div_clk),
        .meas_ready (meas_ready),
        .meas_valid (meas_valid),
        .period     (period),
        .high_time  (high_time),
        .stuck      (stuck),
        .overrun    (overrun),
        .state_o    (state_o)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    // Divider stand-in: registered output, high for floor(N/2) of every N cycles.
    int divisor = 0;
    bit force_high = 1'b0;
    int ph = 0;
    always @(posedge clk_in) begin
        #1;
        if (divisor >= 2) ph = (ph + 1 >= divisor) ? 0 : ph + 1;
        else ph = 0;
        div_clk = force_high ? 1'b1 : (divisor >= 2 && ph < divisor / 2);
    end

    // Reference model: timestamps of edges, results = differences of timestamps.
    logic [W-1:0] exp_q[$];
    bit     m_prev = 1'b0, m_valid = 1'b0, m_stuck = 1'b0, m_ovr = 1'b0;
    int     m_phase = 0;   // 0 idle, 1 waiting for first rise, 2 measuring
    longint t = 0, last_rise = 0, fall_t = 0;
    bit     fall_seen = 1'b0;
    always @(posedge clk_in) begin
        bit rise, fall, done;
        logic [W-1:0] res;
        t++;
        rise = div_clk & ~m_prev;
        fall = ~div_clk & m_prev;
        done = 1'b0;
        res  = '0;
        if (!rst_n) begin
            m_prev = 1'b0; m_phase = 0; m_valid = 1'b0; m_stuck = 1'b0; m_ovr = 1'b0;
            exp_q.delete();
        end else begin
            m_prev = div_clk;
            if (!enable) begin
                m_phase = 0; m_valid = 1'b0; m_stuck = 1'b0; m_ovr = 1'b0;
                exp_q.delete();
            end else begin
                if (rise) m_stuck = 1'b0;
                if (m_phase == 0) begin
                    m_phase = 1;
                end else if (m_phase == 1) begin
                    if (rise) begin
                        m_phase = 2; last_rise = t; fall_seen = 1'b0;
                    end
                end else begin
                    if (rise) begin
                        done = 1'b1;
                        res  = {CNT_W'(t - last_rise), CNT_W'(fall_t - last_rise)};
                        last_rise = t; fall_seen = 1'b0;
                    end else if (!fall_seen && fall) begin
                        fall_seen = 1'b1; fall_t = t;
                    end else if (t - last_rise == TIMEOUT) begin
                        m_stuck = 1'b1; m_phase = 1;
                    end
                end
                if (done) begin
                    if (!m_valid || meas_ready) begin
                        exp_q.push_back(res);
                        m_valid = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (m_valid && meas_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: flags every cycle, result on every transfer, stability while stalled.
    logic [W-1:0] last_out = '0;
    bit hold_chk = 1'b0;
    always @(negedge clk_in) begin
        meas_result_t got;
        check("meas_valid", meas_valid, m_valid);
        check("stuck", stuck, m_stuck);
        check("overrun", overrun, m_ovr);
        if (hold_chk) check("held_result", {period, high_time}, last_out);
        hold_chk = meas_valid && !meas_ready && enable && rst_n;
        last_out = {period, high_time};
        if (meas_valid && meas_ready) begin
            got = {period, high_time};
            if (exp_q.size() == 0) begin
                check("unexpected_result", got, 64'hFFFF_FFFF);
            end else begin
                check("result", got, exp_q.pop_front());
            end
        end
    end

    task automatic wait_valid(input string name, input int max_cycles);
        bit found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            tick(1);
            if (meas_valid) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    task automatic wait_state(input string name, input mon_state_e s, input int max_cycles);
        bit found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            tick(1);
            if (state_o == s) found = 1'b1;
        end
        check(name, found, 1);
    endtask

    // Driver
    initial begin
        tick(3);
        check("rst_valid", meas_valid, 0);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_state", state_o, IDLE);

        // Steady divisor 4, always ready.
        rst_n = 1'b1; divisor = 4; meas_ready = 1'b1; enable = 1'b1;
        tick(40);
        check("d4_period", period, 4);
        check("d4_high", high_time, 2);
        check("d4_overrun", overrun, 0);

        // Divisor 5 with consumer stalled, then released.
        divisor = 5;
        tick(20);
        meas_ready = 1'b0;
        tick(40);
        check("d5_valid", meas_valid, 1);
        check("d5_period", period, 5);
        check("d5_high", high_time, 2);
        check("d5_overrun", overrun, 1);
        meas_ready = 1'b1;
        tick(20);
        check("d5_overrun_sticky", overrun, 1);
        enable = 1'b0;
        tick(1);
        check("dis_overrun", overrun, 0);
        check("dis_state", state_o, IDLE);

        // Stopped divided clock while armed, then a healthy one, then forced high.
        divisor = 1; enable = 1'b1;
        tick(40);
        check("d1_stuck", stuck, 0);
        check("d1_valid", meas_valid, 0);
        check("d1_state", state_o, ARM);
        divisor = 6;
        tick(40);
        check("d6_period", period, 6);
        check("d6_high", high_time, 3);
        meas_ready = 1'b0;
        wait_valid("wait_d6_valid", 20);
        force_high = 1'b1;
        tick(25);
        check("forced_stuck", stuck, 1);
        check("forced_state", state_o, ARM);
        check("forced_valid", meas_valid, 1);
        enable = 1'b0;
        tick(1);
        check("dis2_valid", meas_valid, 0);
        check("dis2_stuck", stuck, 0);
        check("dis2_overrun", overrun, 0);
        force_high = 1'b0; divisor = 3; meas_ready = 1'b1; enable = 1'b1;
        tick(30);
        check("d3_period", period, 3);
        check("d3_high", high_time, 1);

        // Ready pulsed at each phase of a divisor-4 stream to hit accept+complete.
        divisor = 4;
        for (int off = 0; off < 4; off++) begin
            meas_ready = 1'b0;
            tick(8 + off);
            meas_ready = 1'b1;
            tick(1);
            meas_ready = 1'b0;
            tick(6);
        end

        // Random divisors with random back-pressure.
        for (int r = 0; r < 10; r++) begin
            divisor = $urandom_range(2, 9);
            for (int c = 0; c < 60; c++) begin
                meas_ready = 1'($urandom_range(0, 1));
                tick(1);
            end
        end

        // Reset in the low phase of a divisor-8 measurement.
        divisor = 8; meas_ready = 1'b1;
        tick(30);
        wait_state("wait_meas_low", MEAS_LOW, 16);
        rst_n = 1'b0;
        tick(1);
        check("mrst_valid", meas_valid, 0);
        check("mrst_period", period, 0);
        check("mrst_high", high_time, 0);
        check("mrst_state", state_o, IDLE);
        rst_n = 1'b1;
        tick(40);
        check("d8_period", period, 8);
        check("d8_high", high_time, 4);

        tick(5);
        check("leftover", exp_q.size(), meas_valid ? 1 : 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_clock_monitor.md
Name: div_clock_monitor

Overview:
- Measures the divided clock produced by the programmable frequency divider and reports period and high time, both in clk_in cycles.
- Sits directly downstream of the divider in the same clk_in domain and samples its registered clk_out as a data signal (div_clk).
- Results are delivered on a valid/ready interface and feed divisor-calibration and self-test logic.
- A timeout flags a stuck divided clock, which occurs for divisor 0 or 1.

Parameters:
- CNT_W, 16, width of the cycle counter and result fields.
- TIMEOUT, 1000, clk_in cycles without a div_clk edge before stuck is asserted; must be ≤ 2^CNT_W-1 and ≥ 2.

Ports:
- clk_in  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  monitor enable; low forces IDLE.
- div_clk  input  1  divided clock from the divider, already registered in the clk_in domain.
- meas_ready  input  1  consumer accepts the result.
- meas_valid  output  1  result registers hold an unconsumed measurement.
- period  output  CNT_W  cycles between two successive div_clk rising edges.
- high_time  output  CNT_W  cycles div_clk was high within that period.
- stuck  output  1  no edge seen for TIMEOUT cycles.
- overrun  output  1  sticky; a completed measurement was dropped.

Behaviour:
- Reset (rst_n=0 at a clk_in edge): all outputs 0, state IDLE, div_q=0, cnt=0, hi_cap=0.
- Edge detect:
  - div_q <= div_clk every cycle, including IDLE.
  - rise = div_clk & ~div_q; fall = ~div_clk & div_q.
- Counter:
  - cnt <= 1 on a rise.
  - Otherwise, in MEAS_HIGH/MEAS_LOW, cnt <= cnt+1, saturating at 2^CNT_W-1.
- States:
  - IDLE: enable=1 -> ARM.
  - ARM: discards the partial first period. rise -> MEAS_HIGH.
  - MEAS_HIGH:
    - fall -> hi_cap <= cnt, go to MEAS_LOW.
    - cnt == TIMEOUT -> stuck=1, go to ARM.
  - MEAS_LOW:
    - rise -> result complete with period=cnt and high_time=hi_cap; restart (cnt<=1), stay measuring in MEAS_HIGH back-to-back.
    - cnt == TIMEOUT -> stuck=1, go to ARM.
- stuck clears on the first rise after it was set.
- Worked example, steady divisor N ≥ 2: period = N, high_time = floor(N/2). N=4 gives 4/2; N=5 gives 5/2.
- Output handshake:
  - A result loads period/high_time and sets meas_valid when meas_valid=0, or when meas_valid=1 and meas_ready=1 in the same cycle (the new value replaces the accepted one and meas_valid stays 1).
  - meas_valid=1, meas_ready=1, no new result -> meas_valid <= 0.
  - Completion with meas_valid=1 and meas_ready=0 -> new result dropped, old held stable, overrun <= 1.
  - Result registers never change while meas_valid=1 and meas_ready=0.
  - Latency: result visible one cycle after the cycle in which the closing rise is detected.
- overrun clears only on reset or enable=0.
- enable deassert, any state: next cycle state=IDLE, meas_valid=0, stuck=0, overrun=0, cnt=0. period/high_time hold their last values.
- Reset mid-measurement: same as the reset values above; no partial result is emitted.
- The divider changing divisor mid-stream needs no special handling; the transitional period is reported as measured.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ARM, MEAS_HIGH, MEAS_LOW);
  - default CNT_W/TIMEOUT constants;
  - a result struct {period, high_time}.
- One sub-module, div_edge_detect, holds the div_q register and the rise/fall outputs; it is reused by other clock-observing blocks.
- Counter, FSM and output register stay in the top.

Test Plan:
- Divider with divisor=4, meas_ready=1, enable after reset -> first result period=4, high_time=2; then one result every 4 cycles, overrun=0.
- divisor=5, meas_ready=0 -> one result 5/2 held stable; overrun=1 about 5 cycles later. Raise meas_ready -> next result 5/2 accepted, overrun stays 1 until enable=0.
- divisor=1 (div_clk constant 0), TIMEOUT=20 -> no meas_valid; stuck stays 0 while in ARM. Switch to divisor=6 -> results 6/3, stuck=0. Then force div_clk high for 20 cycles -> stuck=1 at cnt==20, state ARM.
- Result completes in the same cycle meas_ready accepts the old one (divisor=4, ready pulsed on the completion cycle) -> meas_valid stays 1, new value loaded, overrun=0.
- rst_n=0 for one cycle during MEAS_LOW (divisor=8) -> all outputs 0 next cycle; first post-reset result is 8/4, with the partial period discarded.
- enable dropped while meas_valid=1 and stuck=1 -> next cycle meas_valid=0, stuck=0, overrun=0. Re-enable with divisor=3 -> result 3/1.
